// File: rtl/host_mem_responder_if.sv
// Cache-line request/response bundle between the miner's memory controller (master)
// and the host-side responder (slave).
interface host_mem_if #(
  parameter int unsigned CL_SIZE_WIDTH = 512,
  parameter int unsigned ADDR_BITCOUNT = 64
);
  logic                     host_re;
  logic                     host_rgo;
  logic                     host_we;
  logic                     host_wgo;
  logic [ADDR_BITCOUNT-1:0] corrected_address;
  logic [CL_SIZE_WIDTH-1:0] host_data_bus_write_out;
  logic [CL_SIZE_WIDTH-1:0] host_data_bus_read_in;
  logic                     host_rd_ready;
  logic                     host_wr_ready;
  logic                     host_init;
  logic [ADDR_BITCOUNT-1:0] address_offset;
  logic                     addr_err;
  logic                     protocol_err;

  modport master (
    output host_re, host_rgo, host_we, host_wgo, corrected_address, host_data_bus_write_out,
    input  host_data_bus_read_in, host_rd_ready, host_wr_ready, host_init, address_offset,
           addr_err, protocol_err
  );

  modport slave (
    input  host_re, host_rgo, host_we, host_wgo, corrected_address, host_data_bus_write_out,
    output host_data_bus_read_in, host_rd_ready, host_wr_ready, host_init, address_offset,
           addr_err, protocol_err
  );
endinterface

// File: rtl/host_mem_responder.sv
// Host-side cache-line RAM responder: fixed RD/WR latency from accept, one op in flight,
// one-entry pending slot; anything beyond the slot is dropped and flagged with protocol_err.
module host_mem_responder #(
  parameter int unsigned CL_SIZE_WIDTH = 512,
  parameter int unsigned ADDR_BITCOUNT = 64,
  parameter int unsigned DEPTH_LINES   = 256,
  parameter int unsigned RD_LATENCY    = 4,
  parameter int unsigned WR_LATENCY    = 2,
  parameter logic [ADDR_BITCOUNT-1:0] BASE_ADDR = '0
) (
  input logic       clk,
  input logic       rst,
  host_mem_if.slave bus
);
  localparam int unsigned CL      = CL_SIZE_WIDTH;
  localparam int unsigned AW      = ADDR_BITCOUNT;
  localparam int unsigned IDX_W   = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam int unsigned MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [AW-1:0]    DEPTH_A  = AW'(DEPTH_LINES);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_LATENCY - 1);
  localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(DEPTH_LINES - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RD_WAIT, S_WR_WAIT} state_e;

  state_e           state_q, state_d;
  logic [CL-1:0]    mem_q [DEPTH_LINES];
  logic [IDX_W-1:0] clr_cnt_q;
  logic [CNT_W-1:0] lat_cnt_q;
  logic             init_q;
  logic             rd_rdy_q, wr_rdy_q, addr_err_q, proto_err_q;
  logic [CL-1:0]    rd_dat_q;

  logic [IDX_W-1:0] op_idx_q;
  logic             op_err_q;
  logic [CL-1:0]    op_dat_q;

  logic             pend_vld_q, pend_vld_d, pend_wr_q, pend_wr_d;
  logic [AW-1:0]    pend_addr_q, pend_addr_d;
  logic [CL-1:0]    pend_dat_q, pend_dat_d;

  logic             rd_req, wr_req;
  logic             acc_vld, acc_wr, acc_err;
  logic [AW-1:0]    acc_addr, acc_off;
  logic [CL-1:0]    acc_dat;
  logic [IDX_W-1:0] acc_idx;
  logic             new_rd, new_wr, slot_free, proto_err_d;
  logic             rd_fire, wr_fire, fire_err;
  logic [IDX_W-1:0] fire_idx;
  logic [CL-1:0]    fire_dat;
  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [CL-1:0]    mem_wdat;

  assign rd_req = bus.host_re & bus.host_rgo;
  assign wr_req = bus.host_we & bus.host_wgo;

  // Addresses below BASE_ADDR wrap to huge offsets and land in the range error.
  assign acc_off = acc_addr - BASE_ADDR;
  assign acc_err = (acc_off[5:0] != 6'd0) || ((acc_off >> 6) >= DEPTH_A);
  assign acc_idx = acc_off[6 +: IDX_W];

  always_comb begin
    state_d     = state_q;
    acc_vld     = 1'b0;
    acc_wr      = 1'b0;
    acc_addr    = bus.corrected_address;
    acc_dat     = bus.host_data_bus_write_out;
    new_rd      = 1'b0;
    new_wr      = 1'b0;
    slot_free   = 1'b0;
    proto_err_d = 1'b0;
    rd_fire     = 1'b0;
    wr_fire     = 1'b0;
    pend_vld_d  = pend_vld_q;
    pend_wr_d   = pend_wr_q;
    pend_addr_d = pend_addr_q;
    pend_dat_d  = pend_dat_q;

    case (state_q)
      S_INIT: begin
        proto_err_d = rd_req | wr_req;
        if (clr_cnt_q == CLR_LAST) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (pend_vld_q) begin
          acc_vld    = 1'b1;
          acc_wr     = pend_wr_q;
          acc_addr   = pend_addr_q;
          acc_dat    = pend_dat_q;
          pend_vld_d = 1'b0;
          slot_free  = 1'b1;
          new_rd     = rd_req;
          new_wr     = wr_req;
        end else if (rd_req) begin
          acc_vld   = 1'b1;
          slot_free = 1'b1;
          new_wr    = wr_req;
        end else if (wr_req) begin
          acc_vld = 1'b1;
          acc_wr  = 1'b1;
        end
        // A latency of one completes on the accept edge without visiting a wait state.
        if (acc_vld && acc_wr) begin
          if (WR_LATENCY == 1) wr_fire = 1'b1;
          else                 state_d = S_WR_WAIT;
        end else if (acc_vld) begin
          if (RD_LATENCY == 1) rd_fire = 1'b1;
          else                 state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        slot_free = !pend_vld_q;
        new_rd    = rd_req;
        new_wr    = wr_req;
        if (lat_cnt_q == RD_LAST) begin
          rd_fire = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WR_WAIT: begin
        slot_free = !pend_vld_q;
        new_rd    = rd_req;
        new_wr    = wr_req;
        if (lat_cnt_q == WR_LAST) begin
          wr_fire = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase

    // Reads claim the slot before a same-cycle write.
    if (new_rd) begin
      if (slot_free) begin
        pend_vld_d  = 1'b1;
        pend_wr_d   = 1'b0;
        pend_addr_d = bus.corrected_address;
        pend_dat_d  = bus.host_data_bus_write_out;
        slot_free   = 1'b0;
      end else begin
        proto_err_d = 1'b1;
      end
    end
    if (new_wr) begin
      if (slot_free) begin
        pend_vld_d  = 1'b1;
        pend_wr_d   = 1'b1;
        pend_addr_d = bus.corrected_address;
        pend_dat_d  = bus.host_data_bus_write_out;
      end else begin
        proto_err_d = 1'b1;
      end
    end
  end

  assign fire_idx = (state_q == S_IDLE) ? acc_idx : op_idx_q;
  assign fire_err = (state_q == S_IDLE) ? acc_err : op_err_q;
  assign fire_dat = (state_q == S_IDLE) ? acc_dat : op_dat_q;

  assign mem_we   = !rst && ((state_q == S_INIT) || (wr_fire && !fire_err));
  assign mem_widx = (state_q == S_INIT) ? clr_cnt_q : fire_idx;
  assign mem_wdat = (state_q == S_INIT) ? '0 : fire_dat;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      clr_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      init_q      <= 1'b0;
      rd_rdy_q    <= 1'b0;
      wr_rdy_q    <= 1'b0;
      addr_err_q  <= 1'b0;
      proto_err_q <= 1'b0;
      rd_dat_q    <= '0;
      op_idx_q    <= '0;
      op_err_q    <= 1'b0;
      op_dat_q    <= '0;
      pend_vld_q  <= 1'b0;
      pend_wr_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_dat_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) begin
        clr_cnt_q <= clr_cnt_q + 1'b1;
        if (clr_cnt_q == CLR_LAST) init_q <= 1'b1;
      end
      if (acc_vld) begin
        lat_cnt_q <= CNT_W'(1);
        op_idx_q  <= acc_idx;
        op_err_q  <= acc_err;
        op_dat_q  <= acc_dat;
      end else if (state_q == S_RD_WAIT || state_q == S_WR_WAIT) begin
        lat_cnt_q <= lat_cnt_q + 1'b1;
      end
      rd_rdy_q    <= rd_fire;
      wr_rdy_q    <= wr_fire;
      addr_err_q  <= acc_vld && acc_err;
      proto_err_q <= proto_err_d;
      if (rd_fire) rd_dat_q <= fire_err ? '0 : mem_q[fire_idx];
      pend_vld_q  <= pend_vld_d;
      pend_wr_q   <= pend_wr_d;
      pend_addr_q <= pend_addr_d;
      pend_dat_q  <= pend_dat_d;
    end
  end

  assign bus.host_data_bus_read_in = rd_dat_q;
  assign bus.host_rd_ready         = rd_rdy_q;
  assign bus.host_wr_ready         = wr_rdy_q;
  assign bus.host_init             = init_q;
  assign bus.address_offset        = BASE_ADDR;
  assign bus.addr_err              = addr_err_q;
  assign bus.protocol_err          = proto_err_q;
endmodule

// File: tb/tb_host_mem_responder.sv
// Bench for host_mem_responder: directed scenarios plus random isolated ops against a line-array model.
module tb_host_mem_responder;
  localparam int CL    = 512;
  localparam int AW    = 64;
  localparam int DEPTH = 256;
  localparam int RDL   = 4;
  localparam int WRL   = 2;
  localparam logic [AW-1:0] BASE = 64'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  host_mem_if #(.CL_SIZE_WIDTH(CL), .ADDR_BITCOUNT(AW)) bus ();

  host_mem_responder #(
    .CL_SIZE_WIDTH(CL), .ADDR_BITCOUNT(AW), .DEPTH_LINES(DEPTH),
    .RD_LATENCY(RDL), .WR_LATENCY(WRL), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log of output pulses, stamped with the cycle they are visible in.
  int            rd_t[$];
  logic [CL-1:0] rd_d[$];
  int            wr_t[$];
  int            ae_t[$];
  int            pe_t[$];
  always @(negedge clk) begin
    if (bus.host_rd_ready === 1'b1) begin
      rd_t.push_back(cyc);
      rd_d.push_back(bus.host_data_bus_read_in);
    end
    if (bus.host_wr_ready === 1'b1) wr_t.push_back(cyc);
    if (bus.addr_err === 1'b1)      ae_t.push_back(cyc);
    if (bus.protocol_err === 1'b1)  pe_t.push_back(cyc);
  end

  int tests = 0;
  int fails = 0;
  logic [CL-1:0] mem_m [DEPTH];

  task automatic chk(string tag, logic [CL-1:0] obs, logic [CL-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(string tag, int obs, int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - BASE;
    return (off % 64 != 0) || (off / 64 >= DEPTH);
  endfunction

  function automatic int model_idx(logic [AW-1:0] a);
    return int'((a - BASE) / 64);
  endfunction

  function automatic logic [CL-1:0] rand_line();
    logic [CL-1:0] v;
    for (int i = 0; i < CL / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_q();
    rd_t.delete(); rd_d.delete(); wr_t.delete(); ae_t.delete(); pe_t.delete();
  endtask

  task automatic drive(bit r, bit w, logic [AW-1:0] a, logic [CL-1:0] d);
    bus.host_re = r;
    bus.host_rgo = r;
    bus.host_we = w;
    bus.host_wgo = w;
    bus.corrected_address = a;
    bus.host_data_bus_write_out = d;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  endtask

  // Counts cycles with host_init low (bounded) and pokes one read in cycle 6 that must be dropped.
  task automatic wait_init(string tag);
    int n;
    n = 0;
    while (bus.host_init !== 1'b1 && n < 400) begin
      drive(n == 5, 1'b0, BASE, '0);
      n++;
      step(1);
    end
    drive(1'b0, 1'b0, '0, '0);
    chk_i({tag, ".init_len"}, n, DEPTH);
    clear_model();
  endtask

  // One request from an idle responder; checks ready timing, data and error pulses.
  task automatic do_op(bit w, logic [AW-1:0] a, logic [CL-1:0] d, string tag);
    int t;
    logic e;
    logic [CL-1:0] exp;
    e = model_err(a);
    exp = '0;
    if (!e) exp = mem_m[model_idx(a)];
    clr_q();
    t = cyc;
    drive(!w, w, a, d);
    step(1);
    drive(1'b0, 1'b0, '0, '0);
    step(8);
    if (w) begin
      chk_i({tag, ".wr_cnt"}, wr_t.size(), 1);
      if (wr_t.size() > 0) chk_i({tag, ".wr_lat"}, wr_t[0] - t, WRL);
      chk_i({tag, ".rd_cnt"}, rd_t.size(), 0);
      if (!e) mem_m[model_idx(a)] = d;
    end else begin
      chk_i({tag, ".rd_cnt"}, rd_t.size(), 1);
      if (rd_t.size() > 0) begin
        chk_i({tag, ".rd_lat"}, rd_t[0] - t, RDL);
        chk({tag, ".rd_dat"}, rd_d[0], exp);
      end
      chk({tag, ".rd_hold"}, bus.host_data_bus_read_in, exp);
      chk_i({tag, ".wr_cnt"}, wr_t.size(), 0);
    end
    chk_i({tag, ".ae_cnt"}, ae_t.size(), e ? 1 : 0);
    if (e && ae_t.size() > 0) chk_i({tag, ".ae_lat"}, ae_t[0] - t, 1);
    chk_i({tag, ".pe_cnt"}, pe_t.size(), 0);
  endtask

  initial begin
    int t;
    logic [CL-1:0] a5, nd, old;
    logic [AW-1:0] a;
    int idx, k;
    bit w;

    drive(1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    step(2);
    chk("rst.init",  CL'(bus.host_init), '0);
    chk("rst.rdy",   CL'(bus.host_rd_ready), '0);
    chk("rst.wrdy",  CL'(bus.host_wr_ready), '0);
    chk("rst.aerr",  CL'(bus.addr_err), '0);
    chk("rst.perr",  CL'(bus.protocol_err), '0);
    chk("rst.rdat",  bus.host_data_bus_read_in, '0);
    chk("rst.aoff",  CL'(bus.address_offset), CL'(BASE));

    clr_q();
    rst = 1'b0;
    wait_init("boot");
    chk_i("boot.init_drop_pe", pe_t.size(), 1);
    chk_i("boot.init_drop_rd", rd_t.size(), 0);

    do_op(1'b0, BASE, '0, "clr_lo");
    do_op(1'b0, BASE + 64'(DEPTH - 1) * 64, '0, "clr_hi");

    a5 = {64{8'hA5}};
    do_op(1'b1, BASE + 64'h40, a5, "wa5");
    do_op(1'b0, BASE + 64'h40, '0, "ra5");
    if (rd_d.size() > 0) chk("ra5.const", rd_d[0], {64{8'hA5}});

    // Same-cycle read and write: read served first, write from the slot afterwards.
    old = mem_m[2];
    nd = rand_line();
    clr_q();
    t = cyc;
    drive(1'b1, 1'b1, BASE + 64'h80, nd);
    step(1);
    drive(1'b0, 1'b0, '0, '0);
    step(12);
    chk_i("rw.rd_cnt", rd_t.size(), 1);
    if (rd_t.size() > 0) begin
      chk_i("rw.rd_lat", rd_t[0] - t, RDL);
      chk("rw.rd_old", rd_d[0], old);
    end
    chk_i("rw.wr_cnt", wr_t.size(), 1);
    if (wr_t.size() > 0) chk_i("rw.wr_lat", wr_t[0] - t, RDL + WRL);
    chk_i("rw.ae", ae_t.size(), 0);
    chk_i("rw.pe", pe_t.size(), 0);
    mem_m[2] = nd;
    do_op(1'b0, BASE + 64'h80, '0, "rw.readback");

    // Three back-to-back requests: first runs, second pends, third is dropped.
    nd = rand_line();
    old = mem_m[3];
    clr_q();
    t = cyc;
    drive(1'b1, 1'b0, BASE + 64'd3 * 64, '0);
    step(1);
    drive(1'b0, 1'b1, BASE + 64'd4 * 64, nd);
    step(1);
    drive(1'b1, 1'b0, BASE + 64'd5 * 64, '0);
    step(1);
    drive(1'b0, 1'b0, '0, '0);
    step(12);
    chk_i("b2b.rd_cnt", rd_t.size(), 1);
    if (rd_t.size() > 0) begin
      chk_i("b2b.rd_lat", rd_t[0] - t, RDL);
      chk("b2b.rd_dat", rd_d[0], old);
    end
    chk_i("b2b.wr_cnt", wr_t.size(), 1);
    if (wr_t.size() > 0) chk_i("b2b.wr_lat", wr_t[0] - t, RDL + WRL);
    chk_i("b2b.pe", pe_t.size(), 1);
    chk_i("b2b.ae", ae_t.size(), 0);
    mem_m[4] = nd;
    do_op(1'b0, BASE + 64'd4 * 64, '0, "b2b.readback");

    // Address errors: misaligned and one past the end; bad write must not touch RAM.
    do_op(1'b0, BASE + 64'h41, '0, "ae.misalign");
    do_op(1'b0, BASE + 64'(DEPTH) * 64, '0, "ae.range");
    do_op(1'b1, BASE + 64'h41, rand_line(), "ae.wr_misalign");
    do_op(1'b0, BASE + 64'h40, '0, "ae.unchanged");

    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      idx = $urandom_range(0, 15);
      k = $urandom_range(0, 7);
      a = BASE + 64'(idx) * 64;
      if (k == 0) a = a + 64'($urandom_range(1, 63));
      else if (k == 1) a = BASE + 64'(DEPTH + $urandom_range(0, 3)) * 64;
      do_op(w, a, rand_line(), $sformatf("rnd%0d", i));
    end

    // Reset while a read is in flight: no ready, clear restarts, RAM comes back zero.
    do_op(1'b1, BASE + 64'd6 * 64, rand_line(), "rrst.pre");
    clr_q();
    drive(1'b1, 1'b0, BASE + 64'd6 * 64, '0);
    step(1);
    drive(1'b0, 1'b0, '0, '0);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rrst.init", CL'(bus.host_init), '0);
    chk("rrst.rdy",  CL'(bus.host_rd_ready), '0);
    chk("rrst.rdat", bus.host_data_bus_read_in, '0);
    chk("rrst.aerr", CL'(bus.addr_err), '0);
    wait_init("rrst");
    chk_i("rrst.no_rd", rd_t.size(), 0);
    chk_i("rrst.pe", pe_t.size(), 1);
    do_op(1'b0, BASE + 64'd6 * 64, '0, "rrst.cleared");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
